// File: rtl/uart_bus_fifo_periph.sv
// Memory-mapped UART responder on the CPU peripheral bus.
// A TX FIFO buffers CPU stores and drains them to the UART sender through the
// tx_en/tx_status handshake. An RX FIFO captures receiver bytes for the CPU to
// pop by load. A registered level IRQ is driven toward Control.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   rd, wr, addr        bus load/store strobes and byte address
//   wdata, rdata        store data in; combinational load data out (0 when rd=0)
//   tx_data, tx_en      byte and send request to the UART sender
//   tx_status           sender idle (1) / frame in progress (0)
//   rx_data, rx_status  receiver byte and byte-ready level
//   irqout              level interrupt request
module uart_bus_fifo_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  output logic        irqout
);

  localparam logic [31:0] TxdAddr   = BASE_ADDR;
  localparam logic [31:0] RxdAddr   = BASE_ADDR + 32'd4;
  localparam logic [31:0] ConAddr   = BASE_ADDR + 32'd8;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic [1:0] {StIdle, StSend, StBusy} tx_state_e;

  tx_state_e tx_state_q, tx_state_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [AW:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [7:0]    tx_data_q;
  logic          rx_prev_q;
  logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic          rx_ie_q, tx_ie_q;
  logic          irq_q;

  logic tx_push, tx_push_ok, tx_pop, tx_full, tx_empty, tx_idle;
  logic rx_push, rx_push_ok, rx_pop, rx_full, rx_empty;
  logic con_wr;

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:8]};

  assign tx_full  = (tx_count_q == FullCount);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == FullCount);
  assign rx_empty = (rx_count_q == '0);
  assign tx_idle  = tx_empty && (tx_state_q == StIdle);

  assign tx_push = wr && (addr == TxdAddr);
  assign con_wr  = wr && (addr == ConAddr);
  assign tx_pop  = (tx_state_q == StIdle) && !tx_empty && tx_status;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);

  assign rx_push    = rx_status && !rx_prev_q;
  assign rx_pop     = rd && (addr == RxdAddr) && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);

  always_comb begin
    tx_count_d = tx_count_q;
    unique case ({tx_push_ok, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CountOne;
      2'b01:   tx_count_d = tx_count_q - CountOne;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_count_d = rx_count_q;
    unique case ({rx_push_ok, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CountOne;
      2'b01:   rx_count_d = rx_count_q - CountOne;
      default: rx_count_d = rx_count_q;
    endcase
  end

  // A new overflow in the same cycle as a W1C clear wins, so no event is lost.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (con_wr && wdata[3]) rx_ovf_d = 1'b0;
    if (con_wr && wdata[4]) tx_ovf_d = 1'b0;
    if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
    if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      StIdle:  if (tx_pop) tx_state_d = StSend;
      StSend:  if (!tx_status) tx_state_d = StBusy;
      StBusy:  if (tx_status) tx_state_d = StIdle;
      default: tx_state_d = StIdle;
    endcase
  end

  // Storage carries no reset: contents are only observable through non-zero counts.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr_q] <= wdata[7:0];
    if (rx_push_ok) rx_mem[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StIdle;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_data_q  <= '0;
      rx_prev_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ie_q    <= 1'b0;
      tx_ie_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      rx_prev_q  <= rx_status;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
      if (tx_push_ok) tx_wptr_q <= tx_wptr_q + PtrOne;
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + PtrOne;
        tx_data_q <= tx_mem[tx_rptr_q];
      end
      if (rx_push_ok) rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop)     rx_rptr_q <= rx_rptr_q + PtrOne;
      if (con_wr) begin
        rx_ie_q <= wdata[5];
        tx_ie_q <= wdata[6];
      end
      irq_q <= (rx_ie_q && !rx_empty) || (tx_ie_q && tx_idle);
    end
  end

  assign tx_en   = (tx_state_q == StSend);
  assign tx_data = tx_data_q;
  assign irqout  = irq_q;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == RxdAddr) begin
        if (!rx_empty) rdata = {24'b0, rx_mem[rx_rptr_q]};
      end else if (addr == ConAddr) begin
        rdata = {16'b0, 8'(rx_count_q), 1'b0, tx_ie_q, rx_ie_q, tx_ovf_q, rx_ovf_q,
                 tx_idle, tx_full, !rx_empty};
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_fifo_periph.sv
// Scoreboard bench for uart_bus_fifo_periph: stimulus queues expected load data
// and expected sender bytes; a monitor compares whenever a load is active or
// tx_en rises.
module tb_uart_bus_fifo_periph;

  localparam logic [31:0] Txd = 32'h4000_0018;
  localparam logic [31:0] Rxd = 32'h4000_001C;
  localparam logic [31:0] Con = 32'h4000_0020;

  logic        clk, reset, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_en, tx_status, rx_status, irqout;
  logic        snd_idle, hold_busy;

  int checks   = 0;
  int failures = 0;
  int tx_pulses = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];

  assign tx_status = snd_idle && !hold_busy;

  uart_bus_fifo_periph dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_status (tx_status),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .irqout    (irqout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Sender model: busy for 20 cycles after it sees a send request.
  initial begin
    snd_idle = 1'b1;
    forever begin
      @(posedge clk);
      if (tx_en) begin
        #1 snd_idle = 1'b0;
        repeat (20) @(posedge clk);
        #1 snd_idle = 1'b1;
      end
    end
  end

  // Monitor: compares load data and each new send request against the queues.
  initial begin
    logic    tx_en_prev;
    rd_exp_t e;
    tx_en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && !tx_en_prev) begin
        tx_pulses++;
        if (tx_q.size() == 0) check("unexpected_tx_en", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
      tx_en_prev = tx_en;
      if (rd) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", rdata, 32'hFFFF_FFFF);
        end else begin
          e = rd_q.pop_front();
          check(e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cycle(1);
    wr = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.name = name; e.exp = exp;
    rd_q.push_back(e);
    rd = 1'b1; addr = a;
    cycle(1);
    rd = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int hold);
    rx_data = b; rx_status = 1'b1;
    cycle(hold);
    rx_status = 1'b0;
    cycle(1);
  endtask

  initial begin
    int waited;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rx_data = '0; rx_status = 1'b0; hold_busy = 1'b0;
    cycle(3);
    check("reset_tx_en", 32'(tx_en), 32'h0);
    check("reset_irq", 32'(irqout), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    reset = 1'b1;
    cycle(1);
    bus_read("reset_con", Con, 32'h04);

    // 1: two bytes through the sender handshake
    tx_q.push_back(8'h41);
    tx_q.push_back(8'h42);
    bus_write(Txd, 32'h41);
    bus_write(Txd, 32'h42);
    cycle(70);
    check("t1_pulses", 32'(tx_pulses), 32'd2);
    bus_read("t1_con_idle", Con, 32'h04);

    // 2: TX overflow with sender held busy, then W1C and drain
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) bus_write(Txd, 32'h10 + 32'(i));
    bus_read("t2_con_full", Con, 32'h02);
    bus_write(Txd, 32'h99);
    bus_read("t2_con_ovf", Con, 32'h12);
    bus_write(Con, 32'h10);
    bus_read("t2_con_clr", Con, 32'h02);
    for (int i = 0; i < 8; i++) tx_q.push_back(8'h10 + 8'(i));
    hold_busy = 1'b0;
    cycle(260);
    check("t2_pulses", 32'(tx_pulses), 32'd10);
    bus_read("t2_con_drained", Con, 32'h04);

    // 3: one push per rx_status edge; empty reads return 0
    rx_byte(8'h5A, 3);
    bus_read("t3_con", Con, 32'h0105);
    bus_read("t3_rxd", Rxd, 32'h5A);
    bus_read("t3_rxd_empty", Rxd, 32'h0);
    bus_read("t3_txd_read", Txd, 32'h0);
    bus_read("t3_unmapped", 32'h4000_0030, 32'h0);

    // 4: full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) rx_byte(8'h80 + 8'(i), 1);
    bus_read("t4_con_full", Con, 32'h0805);
    rx_data = 8'h88; rx_status = 1'b1;
    bus_read("t4_rxd_pp", Rxd, 32'h80);
    rx_status = 1'b0;
    cycle(1);
    bus_read("t4_con_after", Con, 32'h0805);
    for (int i = 1; i <= 8; i++) bus_read("t4_rxd_order", Rxd, 32'h80 + 32'(i));
    bus_read("t4_con_empty", Con, 32'h04);

    // 5: rx interrupt timing
    bus_write(Con, 32'h20);
    rx_data = 8'h3C; rx_status = 1'b1;
    cycle(1);
    check("t5_irq_at_push", 32'(irqout), 32'h0);
    rx_status = 1'b0;
    cycle(1);
    check("t5_irq_after", 32'(irqout), 32'h1);
    bus_read("t5_rxd", Rxd, 32'h3C);
    check("t5_irq_pop_edge", 32'(irqout), 32'h1);
    cycle(1);
    check("t5_irq_cleared", 32'(irqout), 32'h0);
    bus_write(Con, 32'h0);

    // 6: reset during SEND
    tx_q.push_back(8'h77);
    bus_write(Txd, 32'h77);
    bus_write(Txd, 32'h78);
    waited = 0;
    while (!tx_en && waited < 10) begin
      cycle(1);
      waited++;
    end
    check("t6_reached_send", 32'(tx_en), 32'h1);
    #5 reset = 1'b0;
    #1 check("t6_tx_en_async", 32'(tx_en), 32'h0);
    check("t6_tx_data_rst", 32'(tx_data), 32'h0);
    cycle(2);
    reset = 1'b1;
    cycle(2);
    check("t6_irq", 32'(irqout), 32'h0);
    bus_read("t6_con", Con, 32'h04);
    cycle(10);
    check("t6_pulses", 32'(tx_pulses), 32'd11);

    cycle(2);
    check("tx_q_leftover", 32'(tx_q.size()), 32'd0);
    check("rd_q_leftover", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
